// File: rtl/gnrl_dconv_acq_ctrl.sv
// rtl/gnrl_dconv_acq_ctrl.sv - NMR DDC acquisition sequencer: dead-time, echo windows, I/Q write alignment.
// Define GNRL_DCONV_DCCAL_EN to measure the ADC DC level on start instead of using dcval_manual.
module gnrl_dconv_acq_ctrl #(
    parameter int ADC_PHYS_WIDTH = 14,
    parameter int CNT_WIDTH      = 24,
    parameter int ECHO_WIDTH     = 16,
    parameter int DCAVG_LOG2     = 8,
    parameter int DCONV_LAT      = 2
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CNT_WIDTH-1:0]          init_delay,
    input  logic [CNT_WIDTH-1:0]          echo_len,
    input  logic [CNT_WIDTH-1:0]          echo_gap,
    input  logic [ECHO_WIDTH-1:0]         echo_cnt,
    input  logic [ADC_PHYS_WIDTH:0]       dcval_manual,
    input  logic [ADC_PHYS_WIDTH-1:0]     adc_data_in,
    output logic                          conv_en,
    output logic [ADC_PHYS_WIDTH:0]       adc_dcval_subtractor,
    input  logic [ADC_PHYS_WIDTH:0]       data_i,
    input  logic [ADC_PHYS_WIDTH:0]       data_q,
    output logic                          wr_en,
    output logic [2*ADC_PHYS_WIDTH+1:0]   wr_data,
    input  logic                          wr_full,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    typedef enum logic [2:0] {S_IDLE, S_DCCAL, S_DELAY, S_ACQ, S_GAP, S_FLUSH} state_t;

    state_t                        r_state;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic [CNT_WIDTH-1:0]          r_len;
    logic [CNT_WIDTH-1:0]          r_gap;
    logic [ECHO_WIDTH-1:0]         r_echo;
    logic                          r_conv_en;
    logic [DCONV_LAT-1:0]          r_pipe;
    logic [2*ADC_PHYS_WIDTH+1:0]   r_wr_data;
    logic [ADC_PHYS_WIDTH:0]       r_dcval;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_overflow;

    logic [DCONV_LAT:0]            w_pipe_in;
    logic [CNT_WIDTH-1:0]          w_len_m1;

    // w_pipe_in[DCONV_LAT-1] is the next wr_en, w_pipe_in[DCONV_LAT] the current one
    assign w_pipe_in = {r_pipe, r_conv_en};
    assign w_len_m1  = (r_len == '0) ? '0 : r_len - CNT_WIDTH'(1);

`ifdef GNRL_DCONV_DCCAL_EN
    localparam int ACC_W = ADC_PHYS_WIDTH + DCAVG_LOG2;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_WIDTH-1:0] r_delay;
    logic [ACC_W-1:0]     w_acc_next;
    logic [ADC_PHYS_WIDTH:0] w_unused_manual;
    assign w_acc_next      = r_acc + ACC_W'(adc_data_in);
    assign w_unused_manual = dcval_manual;
`else
    logic [ADC_PHYS_WIDTH-1:0] w_unused_adc;
    logic [DCAVG_LOG2-1:0]     w_unused_cal;
    assign w_unused_adc = adc_data_in;
    assign w_unused_cal = '0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_gap      <= '0;
            r_echo     <= '0;
            r_conv_en  <= 1'b0;
            r_pipe     <= '0;
            r_wr_data  <= '0;
            r_dcval    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef GNRL_DCONV_DCCAL_EN
            r_acc      <= '0;
            r_delay    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_pipe <= w_pipe_in[DCONV_LAT-1:0];
            if (w_pipe_in[DCONV_LAT-1]) r_wr_data <= {data_i, data_q};
            if (w_pipe_in[DCONV_LAT] && wr_full) r_overflow <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_len      <= echo_len;
                        r_gap      <= echo_gap;
                        r_echo     <= echo_cnt;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef GNRL_DCONV_DCCAL_EN
                        r_delay    <= init_delay;
                        r_acc      <= '0;
                        r_cnt      <= CNT_WIDTH'((2 ** DCAVG_LOG2) - 1);
                        r_state    <= S_DCCAL;
`else
                        r_dcval    <= dcval_manual;
                        r_cnt      <= init_delay;
                        r_state    <= S_DELAY;
`endif
                    end
                end
`ifdef GNRL_DCONV_DCCAL_EN
                S_DCCAL: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == '0) begin
                        r_dcval <= {1'b0, w_acc_next[ACC_W-1:DCAVG_LOG2]};
                        r_cnt   <= r_delay;
                        r_state <= S_DELAY;
                    end else begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end
                end
`endif
                S_DELAY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end else if (r_echo == '0) begin
                        r_cnt   <= CNT_WIDTH'(DCONV_LAT - 1);
                        r_state <= S_FLUSH;
                    end else begin
                        r_conv_en <= (r_len != '0);
                        r_cnt     <= w_len_m1;
                        r_state   <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end else begin
                        r_echo <= r_echo - ECHO_WIDTH'(1);
                        if (r_echo > ECHO_WIDTH'(1)) begin
                            if (r_gap == '0) begin
                                // back-to-back windows keep conv_en high across the boundary
                                r_conv_en <= (r_len != '0);
                                r_cnt     <= w_len_m1;
                            end else begin
                                r_conv_en <= 1'b0;
                                r_cnt     <= r_gap - CNT_WIDTH'(1);
                                r_state   <= S_GAP;
                            end
                        end else begin
                            r_conv_en <= 1'b0;
                            r_cnt     <= CNT_WIDTH'(DCONV_LAT - 1);
                            r_state   <= S_FLUSH;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end else begin
                        r_conv_en <= (r_len != '0);
                        r_cnt     <= w_len_m1;
                        r_state   <= S_ACQ;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (abort && r_state != S_IDLE) begin
                r_state   <= S_IDLE;
                r_conv_en <= 1'b0;
                r_pipe    <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
            end
        end
    end

    assign conv_en              = r_conv_en;
    assign wr_en                = r_pipe[DCONV_LAT-1];
    assign wr_data              = r_wr_data;
    assign adc_dcval_subtractor = r_dcval;
    assign busy                 = r_busy;
    assign done                 = r_done;
    assign overflow             = r_overflow;

endmodule

// File: tb/tb_gnrl_dconv_acq_ctrl.sv
// tb/tb_gnrl_dconv_acq_ctrl.sv - directed scoreboard bench for gnrl_dconv_acq_ctrl.
module tb_gnrl_dconv_acq_ctrl;

`ifdef GNRL_DCONV_DCCAL_EN
    localparam int C = 16;
`else
    localparam int C = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start, abort, wr_full;
    logic [23:0] init_delay, echo_len, echo_gap;
    logic [15:0] echo_cnt;
    logic [14:0] dcval_manual;
    logic [13:0] adc_data_in;
    logic [13:0] adc_const;
    logic        adc_alt;
    logic [14:0] data_i, data_q;
    logic        conv_en, wr_en, busy, done, overflow;
    logic [14:0] adc_dcval_subtractor;
    logic [29:0] wr_data;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [29:0] sb[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign data_i      = 15'(cyc);
    assign data_q      = 15'(cyc) ^ 15'h5A5A;
    assign adc_data_in = adc_alt ? (cyc[0] ? 14'd1011 : 14'd1000) : adc_const;

    gnrl_dconv_acq_ctrl #(
        .ADC_PHYS_WIDTH(14), .CNT_WIDTH(24), .ECHO_WIDTH(16), .DCAVG_LOG2(4), .DCONV_LAT(2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
        .init_delay(init_delay), .echo_len(echo_len), .echo_gap(echo_gap), .echo_cnt(echo_cnt),
        .dcval_manual(dcval_manual), .adc_data_in(adc_data_in), .conv_en(conv_en),
        .adc_dcval_subtractor(adc_dcval_subtractor), .data_i(data_i), .data_q(data_q),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] exp_data(input int e);
        logic [14:0] v;
        v = 15'(e);
        return {v, v ^ 15'h5A5A};
    endfunction

    always @(negedge CLK) begin
        if (!RESET && wr_en) begin
            if (sb.size() == 0) chk("sb_extra_write", 32'd1, 32'd0);
            else chk("wr_data", 32'(wr_data), 32'(sb.pop_front()));
        end
    end

    task automatic wait_to(input int e);
        while (cyc <= e) @(negedge CLK);
    endtask

    task automatic do_start(output int s);
        @(posedge CLK);
        #1 start = 1'b1;
        s = cyc;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic set_cfg(input int d, input int l, input int g, input int n);
        init_delay = 24'(d);
        echo_len   = 24'(l);
        echo_gap   = 24'(g);
        echo_cnt   = 16'(n);
    endtask

    function automatic logic [14:0] exp_sub();
`ifdef GNRL_DCONV_DCCAL_EN
        return {1'b0, adc_const};
`else
        return dcval_manual;
`endif
    endfunction

    task automatic run_main(input bit inject, input bit full2);
        int s;
        set_cfg(10, 4, 3, 2);
        do_start(s);
        for (int k = 13; k <= 16; k++) sb.push_back(exp_data(s + C + k));
        for (int k = 20; k <= 23; k++) sb.push_back(exp_data(s + C + k));
        set_cfg(1, 1, 1, 1);
        for (int k = 0; k <= 25; k++) begin
            wait_to(s + C + k);
            chk("main_conv_en", 32'(conv_en), 32'((k >= 11 && k <= 14) || (k >= 18 && k <= 21)));
            chk("main_wr_en", 32'(wr_en), 32'((k >= 13 && k <= 16) || (k >= 20 && k <= 23)));
            chk("main_busy", 32'(busy), 32'(k < 24));
            chk("main_done", 32'(done), 32'(k == 24));
            if (k == 0) chk("ovf_cleared_on_start", 32'(overflow), 32'd0);
            if (k == 11) chk("subtractor", 32'(adc_dcval_subtractor), 32'(exp_sub()));
            if (full2 && k == 19) chk("ovf_before_drop", 32'(overflow), 32'd0);
            if (full2 && (k == 22 || k == 25)) chk("ovf_sticky", 32'(overflow), 32'd1);
            if (!full2 && k == 25) chk("ovf_none", 32'(overflow), 32'd0);
            start   = inject && (k == 5 || k == 12);
            wr_full = full2 && (k >= 17 && k <= 23);
        end
        start   = 1'b0;
        wr_full = 1'b0;
        chk("main_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int s;
        bit seen;
        RESET = 1'b1; start = 1'b0; abort = 1'b0; wr_full = 1'b0;
        adc_const = 14'd1024; adc_alt = 1'b0; dcval_manual = 15'h1234;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        chk("rst_conv_en", 32'(conv_en), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_sub", 32'(adc_dcval_subtractor), 32'd0);
        RESET = 1'b0;

        run_main(1'b1, 1'b0);
        run_main(1'b0, 1'b1);
        run_main(1'b0, 1'b0);

        // abort mid-window
        set_cfg(10, 4, 3, 2);
        do_start(s);
        sb.push_back(exp_data(s + C + 13));
        for (int k = 0; k <= 20; k++) begin
            wait_to(s + C + k);
            chk("abort_conv_en", 32'(conv_en), 32'(k >= 11 && k <= 13));
            chk("abort_wr_en", 32'(wr_en), 32'(k == 13));
            chk("abort_busy", 32'(busy), 32'(k < 14));
            chk("abort_no_done", 32'(done), 32'd0);
            abort = (k == 13);
        end
        abort = 1'b0;
        chk("abort_sub_kept", 32'(adc_dcval_subtractor), 32'(exp_sub()));
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        run_main(1'b0, 1'b0);

        // no windows
        set_cfg(5, 4, 3, 0);
        do_start(s);
        for (int k = 0; k <= 10; k++) begin
            wait_to(s + C + k);
            chk("cnt0_conv_en", 32'(conv_en), 32'd0);
            chk("cnt0_done", 32'(done), 32'(k == 8));
        end

        // zero-length windows
        set_cfg(3, 0, 2, 3);
        do_start(s);
        seen = 1'b0;
        for (int k = 0; k <= 60 && !seen; k++) begin
            wait_to(s + C + k);
            chk("len0_conv_en", 32'(conv_en), 32'd0);
            seen = done;
        end
        chk("len0_done_seen", 32'(seen), 32'd1);

        // async reset mid-gap
        set_cfg(10, 4, 3, 2);
        do_start(s);
        for (int k = 13; k <= 16; k++) sb.push_back(exp_data(s + C + k));
        wait_to(s + C + 16);
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_conv_en", 32'(conv_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr_data", 32'(wr_data), 32'd0);
        chk("arst_sub", 32'(adc_dcval_subtractor), 32'd0);
        #1 RESET = 1'b0;
        chk("arst_sb_empty", 32'(sb.size()), 32'd0);
        run_main(1'b0, 1'b0);

`ifdef GNRL_DCONV_DCCAL_EN
        adc_alt = 1'b1;
        set_cfg(2, 1, 1, 0);
        do_start(s);
        wait_to(s + C + 6);
        chk("dccal_alt_sub", 32'(adc_dcval_subtractor), 32'd1005);
        chk("dccal_alt_idle", 32'(busy), 32'd0);
        adc_alt = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
